pwm_bank: RTL and testbench



---
 rtl/pwm_bank_if.sv | 15 +
 rtl/pwm_bank.sv | 147 ++++++++++++++
 tb/tb_pwm_bank.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// Register bus between a processor and the PWM bank.
// The master drives the strobes, address and write data; the slave returns registered read data.
interface pwm_bank_if #(
    parameter int AW = 8
);
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   d_in;
    logic [31:0]   d_out;

    modport master (output cs, rd, wr, addr, d_in, input d_out);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/pwm_bank.sv
// Bank of NCH PWM channels with double-buffered period/duty and a global counter sync.
// pwm_chan holds one channel's state; pwm_bank decodes the bus and muxes the read data.

module pwm_chan #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_we,
    input  logic          per_we,
    input  logic          duty_we,
    input  logic          sync,
    input  logic [CW-1:0] wdata,
    output logic          en,
    output logic          pol,
    output logic [CW-1:0] per_pend,
    output logic [CW-1:0] duty_pend,
    output logic [CW-1:0] cnt,
    output logic          pwm
);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic          en_q, en_d, pol_q, pol_d, pwm_q, pwm_d;
    logic [CW-1:0] per_pend_q, per_pend_d, duty_pend_q, duty_pend_d;
    logic [CW-1:0] per_act_q, per_act_d, duty_act_q, duty_act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap, load;

    always_comb begin
        en_d        = ctrl_we ? wdata[0] : en_q;
        pol_d       = ctrl_we ? wdata[1] : pol_q;
        per_pend_d  = per_we  ? wdata    : per_pend_q;
        duty_pend_d = duty_we ? wdata    : duty_pend_q;
        // A zero active period behaves as a wrap on every cycle.
        wrap        = (per_act_q == '0) || (cnt_q == per_act_q - ONE);
        // Loads sample the pending registers before this edge's write lands,
        // so a write coinciding with a wrap waits for the following wrap.
        load        = !en_q || !en_d || sync || wrap;
        cnt_d       = load ? '0          : cnt_q + ONE;
        per_act_d   = load ? per_pend_q  : per_act_q;
        duty_act_d  = load ? duty_pend_q : duty_act_q;
        pwm_d       = pol_q;
        if (en_q && (per_act_q != '0))
            pwm_d = (cnt_q < duty_act_q) ^ pol_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            pol_q       <= 1'b0;
            per_pend_q  <= '0;
            duty_pend_q <= '0;
            per_act_q   <= '0;
            duty_act_q  <= '0;
            cnt_q       <= '0;
            pwm_q       <= 1'b0;
        end else begin
            en_q        <= en_d;
            pol_q       <= pol_d;
            per_pend_q  <= per_pend_d;
            duty_pend_q <= duty_pend_d;
            per_act_q   <= per_act_d;
            duty_act_q  <= duty_act_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
        end
    end

    assign en        = en_q;
    assign pol       = pol_q;
    assign per_pend  = per_pend_q;
    assign duty_pend = duty_pend_q;
    assign cnt       = cnt_q;
    assign pwm       = pwm_q;
endmodule

module pwm_bank #(
    parameter int NCH = 8,
    parameter int CW  = 32,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    pwm_bank_if.slave      bus,
    output logic [NCH-1:0] pwm
);
    localparam logic [AW-1:0] SYNC_ADDR = AW'(8'hF0);

    logic                   wr_en, rd_en;
    logic [NCH-1:0]         ctrl_we, per_we, duty_we, sync;
    logic [NCH-1:0]         en, pol;
    logic [NCH-1:0][CW-1:0] per_pend, duty_pend, cnt;
    logic [31:0]            rd_data, d_out_q, d_out_d;

    assign wr_en = bus.cs && bus.wr && !bus.rd;
    assign rd_en = bus.cs && bus.rd && !bus.wr;

    always_comb begin
        ctrl_we = '0;
        per_we  = '0;
        duty_we = '0;
        sync    = '0;
        for (int k = 0; k < NCH; k++) begin
            ctrl_we[k] = wr_en && (bus.addr == AW'(k * 16));
            per_we[k]  = wr_en && (bus.addr == AW'(k * 16 + 4));
            duty_we[k] = wr_en && (bus.addr == AW'(k * 16 + 8));
            sync[k]    = wr_en && (bus.addr == SYNC_ADDR) && bus.d_in[k];
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        pwm_chan #(.CW(CW)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .ctrl_we  (ctrl_we[k]),
            .per_we   (per_we[k]),
            .duty_we  (duty_we[k]),
            .sync     (sync[k]),
            .wdata    (bus.d_in[CW-1:0]),
            .en       (en[k]),
            .pol      (pol[k]),
            .per_pend (per_pend[k]),
            .duty_pend(duty_pend[k]),
            .cnt      (cnt[k]),
            .pwm      (pwm[k])
        );
    end

    // Anything not matching a channel register (including SYNC) reads as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.addr == AW'(k * 16))      rd_data = {30'b0, pol[k], en[k]};
            if (bus.addr == AW'(k * 16 + 4))  rd_data = 32'(per_pend[k]);
            if (bus.addr == AW'(k * 16 + 8))  rd_data = 32'(duty_pend[k]);
            if (bus.addr == AW'(k * 16 + 12)) rd_data = 32'(cnt[k]);
        end
        d_out_d = rd_en ? rd_data : d_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) d_out_q <= '0;
        else     d_out_q <= d_out_d;
    end

    assign bus.d_out = d_out_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: register access, PWM waveforms, double buffering, sync and reset.
module tb_pwm_bank;
    localparam int NCH = 8;
    localparam int CW  = 32;
    localparam int AW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] pwm;
    int             n_chk = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             t_en = 0;
    logic [31:0]    rdv;
    logic [19:0]    v20;
    logic [15:0]    v2, v3;
    logic [7:0]     v8;

    pwm_bank_if #(.AW(AW)) bus();

    pwm_bank #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pwm(pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bwr(input logic [7:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.d_in = d;
        tick();
        bus.cs = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic brd(input logic [7:0] a, output logic [31:0] d);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        tick();
        d = bus.d_out;
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    initial begin
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;

        // 1: reset state
        tick(); tick();
        rst = 1'b0;
        chk("reset_pwm", 32'(pwm), 32'h0);
        chk("reset_dout", bus.d_out, 32'h0);
        brd(8'h04, rdv); chk("rst_per0", rdv, 32'h0);
        brd(8'h0C, rdv); chk("rst_cnt0", rdv, 32'h0);
        brd(8'h00, rdv); chk("rst_ctrl0", rdv, 32'h0);

        // 2: ch0 period 10, duty 3
        bwr(8'h04, 32'd10);
        bwr(8'h08, 32'd3);
        bwr(8'h00, 32'h1);
        t_en = cyc;
        chk("en_edge_pwm0", 32'(pwm[0]), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            v20 = {v20[18:0], pwm[0]};
        end
        chk("ch0_wave_d3", 32'(v20), 32'h000E0380);
        for (int i = 0; i < 10; i++) begin
            brd(8'h0C, rdv);
            chk("ch0_count", rdv, 32'(i));
        end

        // 3: duty update mid-period takes effect at the next wrap
        bwr(8'h08, 32'd7);
        for (int i = 0; i < 20; i++) begin
            tick();
            v20 = {v20[18:0], pwm[0]};
        end
        chk("ch0_duty_swap", 32'(v20), 32'h000C07F1);

        // 4: ch1 100%, then 0% inverted, then period 0
        bwr(8'h14, 32'd4);
        bwr(8'h18, 32'd4);
        bwr(8'h10, 32'h1);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            v8 = {v8[6:0], pwm[1]};
        end
        chk("ch1_full", 32'(v8), 32'hFF);
        bwr(8'h18, 32'd0);
        repeat (5) tick();
        chk("ch1_zero", 32'(pwm[1]), 32'h0);
        bwr(8'h10, 32'h3);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            v8 = {v8[6:0], pwm[1]};
        end
        chk("ch1_zero_inv", 32'(v8), 32'hFF);
        bwr(8'h14, 32'd0);
        repeat (6) tick();
        brd(8'h1C, rdv); chk("ch1_p0_cnt_a", rdv, 32'h0);
        brd(8'h1C, rdv); chk("ch1_p0_cnt_b", rdv, 32'h0);
        chk("ch1_p0_pol", 32'(pwm[1]), 32'h1);

        // 5: ch2/ch3 at different phases, then SYNC
        bwr(8'h24, 32'd8);
        bwr(8'h28, 32'd4);
        bwr(8'h34, 32'd8);
        bwr(8'h38, 32'd4);
        bwr(8'h20, 32'h1);
        repeat (3) tick();
        bwr(8'h30, 32'h1);
        repeat (2) tick();
        bwr(8'hF0, 32'h0C);
        brd(8'h2C, rdv); chk("sync_cnt2", rdv, 32'h0);
        brd(8'h3C, rdv); chk("sync_cnt3", rdv, 32'h1);
        for (int i = 0; i < 16; i++) begin
            tick();
            v2 = {v2[14:0], pwm[2]};
            v3 = {v3[14:0], pwm[3]};
        end
        chk("sync_wave2", 32'(v2), 32'hC3C3);
        chk("sync_wave3", 32'(v3), 32'hC3C3);
        brd(8'h0C, rdv);
        chk("ch0_unsynced", rdv, 32'((cyc - 1 - t_en) % 10));

        // 6: illegal accesses, readback, reset mid-period
        brd(8'h04, rdv); chk("per0_rb", rdv, 32'd10);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 8'h08; bus.d_in = 32'd99;
        tick();
        chk("rdwr_dout_hold", bus.d_out, 32'd10);
        bus.addr = 8'h0C; bus.d_in = 32'd5;
        tick();
        bus.addr = 8'h04;
        tick();
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        brd(8'h08, rdv); chk("rdwr_duty_kept", rdv, 32'd7);
        brd(8'h04, rdv); chk("rdwr_per_kept", rdv, 32'd10);
        bwr(8'hA0, 32'hFFFF);
        brd(8'hA0, rdv); chk("unmapped_rd", rdv, 32'h0);
        brd(8'hF0, rdv); chk("sync_rd", rdv, 32'h0);
        brd(8'h10, rdv); chk("ctrl1_rb", rdv, 32'h3);
        rst = 1'b1;
        tick();
        chk("midrst_pwm", 32'(pwm), 32'h0);
        chk("midrst_dout", bus.d_out, 32'h0);
        rst = 1'b0;
        brd(8'h0C, rdv); chk("midrst_cnt0", rdv, 32'h0);
        brd(8'h1C, rdv); chk("midrst_cnt1", rdv, 32'h0);
        brd(8'h10, rdv); chk("midrst_ctrl1", rdv, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
